tholin_seq_divider: RTL

//   Sequential restoring divider, the inverse of the 4x4 multiplier tile: 8-bit dividend / 4-bit divisor -> 8-bit quotient + 4-bit remainder.

---
 rtl/tholin_div_pkg.sv | 15 +
 rtl/tholin_div_step.sv | 29 ++
 rtl/tholin_seq_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tholin_div_pkg.sv
// Shared types and widths for the nibble-loaded sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tholin_div_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tholin_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: purely combinational.
// Backpressure: none.
module tholin_div_step #(
    parameter int DVS_W = tholin_div_pkg::DVS_W
) (
    input  logic [DVS_W-1:0] r_in,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] r_out,
    output logic             q_bit
);

    logic [DVS_W:0] trial;
    logic [DVS_W:0] diff;

    always_comb begin
        trial = {r_in, dvd_bit};
        diff  = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            r_out = diff[DVS_W-1:0];
            q_bit = 1'b1;
        end else begin
            r_out = trial[DVS_W-1:0];
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/tholin_seq_divider.sv
// Nibble-loaded 8/4 restoring divider, one quotient bit per clock.
// Latency: done 8 edges after the divisor write (1 edge when divisor is zero).
// Backpressure: none; writes during CALC are dropped, host polls done.
module tholin_seq_divider #(
    parameter int DVD_W = tholin_div_pkg::DVD_W,
    parameter int DVS_W = tholin_div_pkg::DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DVS_W-1:0] nib_in,
    input  logic             wr_en,
    input  logic             out_sel,
    output logic [DVD_W-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    import tholin_div_pkg::*;

    localparam int CNT_W = $clog2(DVD_W);

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dividend_q, dividend_d;
    logic [DVS_W-1:0]   divisor_q, divisor_d;
    logic [DVD_W-1:0]   quot_q, quot_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [DVS_W-1:0]   step_r;
    logic               step_q;

    tholin_div_step #(.DVS_W(DVS_W)) u_step (
        .r_in    (rem_q),
        .dvd_bit (dividend_q[cnt_q]),
        .divisor (divisor_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;

        case (state_q)
            LOAD: begin
                if (wr_en) begin
                    case (ptr_q)
                        2'd0: begin
                            dividend_d[DVS_W-1:0] = nib_in;
                            ptr_d = 2'd1;
                        end
                        2'd1: begin
                            dividend_d[DVD_W-1:DVS_W] = nib_in;
                            ptr_d = 2'd2;
                        end
                        default: begin
                            divisor_d = nib_in;
                            ptr_d     = 2'd0;
                            cnt_d     = CNT_W'(DVD_W - 1);
                            rem_d     = '0;
                            quot_d    = '0;
                            state_d   = CALC;
                        end
                    endcase
                end
            end
            CALC: begin
                // A zero divisor spends one CALC cycle, then reports saturated results.
                if (divisor_q == '0) begin
                    quot_d     = '1;
                    rem_d      = '1;
                    div_zero_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    rem_d  = step_r;
                    quot_d = {quot_q[DVD_W-2:0], step_q};
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (wr_en) begin
                    dividend_d[DVS_W-1:0] = nib_in;
                    ptr_d      = 2'd1;
                    quot_d     = '0;
                    rem_d      = '0;
                    done_d     = 1'b0;
                    div_zero_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
                ptr_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            ptr_q      <= 2'd0;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == CALC) || ((state_q == LOAD) && (ptr_q != 2'd0));
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign dout     = out_sel ? {{(DVD_W-DVS_W){1'b0}}, rem_q} : quot_q;

endmodule
